memory_cycle_ecc: RTL and testbench

//  MEM pipeline stage; receiving end of the SEC-DED-protected EX/MEM bundle. Decodes/corrects
//  the 39-bit ALU result, write data and PC+4 words, performs the word-addressed data-memory

---
 rtl/ecc_pkg.sv | 14 +
 rtl/memory_cycle_ecc_secded.sv | 48 ++++
 rtl/memory_cycle_ecc.sv | 158 +++++++++++++++
 tb/tb_memory_cycle_ecc.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared SEC-DED widths and decode status type
package ecc_pkg;

  localparam int ECC_W  = 39;
  localparam int DATA_W = 32;
  localparam int SYN_W  = 6;

  typedef enum logic [1:0] {
    CLEAN  = 2'd0,
    CORR   = 2'd1,
    UNCORR = 2'd2
  } ecc_status_t;

endpackage

// File: rtl/memory_cycle_ecc_secded.sv
// rtl/memory_cycle_ecc_secded.sv - combinational 39-bit SEC-DED decoder (secded_decode_39)
module secded_decode_39
  import ecc_pkg::*;
(
  input  logic [ECC_W-1:0]  code_in,
  output logic [DATA_W-1:0] data_out,
  output ecc_status_t       status,
  output logic [SYN_W-1:0]  syndrome,
  output logic              parity
);

  logic [ECC_W-1:0] fixedCode;

  // Syndrome is the XOR of the Hamming positions holding a 1; parity covers the whole word.
  always_comb begin
    syndrome = '0;
    for (int i = 1; i < ECC_W; i++) begin
      if (code_in[i]) syndrome = syndrome ^ SYN_W'(i);
    end
    parity = ^code_in;
  end

  // Odd parity means one flipped bit at position syndrome (0 = the parity bit itself).
  always_comb begin
    fixedCode = code_in;
    status    = CLEAN;
    if (parity) begin
      status = CORR;
      if (syndrome < SYN_W'(ECC_W)) fixedCode[syndrome] = ~fixedCode[syndrome];
    end else if (syndrome != '0) begin
      status = UNCORR;
    end
  end

  // Data bits occupy the non-power-of-two positions in ascending order.
  always_comb begin
    int j;
    j        = 0;
    data_out = '0;
    for (int i = 1; i < ECC_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        data_out[j] = fixedCode[i];
        j++;
      end
    end
  end

endmodule

// File: rtl/memory_cycle_ecc.sv
// rtl/memory_cycle_ecc.sv - MEM stage with SEC-DED decode, data memory and MEM/WB register; option ECC_ERR_LOG_EN
module memory_cycle_ecc
  import ecc_pkg::*;
#(
  parameter int DMEM_AW = 10,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWriteM,
  input  logic               MemWriteM,
  input  logic               ResultSrcM,
  input  logic [4:0]         RD_M,
  input  logic [ECC_W-1:0]   ALU_ResultM_ECC,
  input  logic [ECC_W-1:0]   WriteDataM_ECC,
  input  logic [ECC_W-1:0]   PCPlus4M_ECC,
  input  logic               err_clr,
  output logic [DATA_W-1:0]  ALU_ResultM_Out,
  output logic               RegWriteW,
  output logic               ResultSrcW,
  output logic [4:0]         RD_W,
  output logic [DATA_W-1:0]  ALU_ResultW,
  output logic [DATA_W-1:0]  ReadDataW,
  output logic [DATA_W-1:0]  PCPlus4W,
  output logic               ecc_corr_pulse,
  output logic               ecc_uncorr_sticky,
  output logic [CNT_W-1:0]   ecc_corr_count
`ifdef ECC_ERR_LOG_EN
  ,
  output logic               err_log_valid,
  output logic [SYN_W:0]     err_log_syn,
  output logic [1:0]         err_log_src
`endif
);

  logic [DATA_W-1:0]  aluData, wdData, pcData;
  ecc_status_t        aluSt, wdSt, pcSt;
  logic [SYN_W-1:0]   aluSyn, wdSyn, pcSyn;
  logic               aluPar, wdPar, pcPar;
  logic               anyUncorr;
  logic               memWe;
  logic [DMEM_AW-1:0] memIdx;
  logic [1:0]         corrNum;
  logic [CNT_W:0]     countSum;
  logic [CNT_W-1:0]   countNext;
  logic [DATA_W-1:0]  dmem [0:(2**DMEM_AW)-1];

  secded_decode_39 uDecAlu (
    .code_in(ALU_ResultM_ECC), .data_out(aluData), .status(aluSt), .syndrome(aluSyn), .parity(aluPar)
  );
  secded_decode_39 uDecWd (
    .code_in(WriteDataM_ECC), .data_out(wdData), .status(wdSt), .syndrome(wdSyn), .parity(wdPar)
  );
  secded_decode_39 uDecPc (
    .code_in(PCPlus4M_ECC), .data_out(pcData), .status(pcSt), .syndrome(pcSyn), .parity(pcPar)
  );

  assign ALU_ResultM_Out = aluData;
  assign anyUncorr       = (aluSt == UNCORR) || (wdSt == UNCORR) || (pcSt == UNCORR);
  assign memIdx          = aluData[DMEM_AW+1:2];
  // A store is dropped if its address or data is untrustworthy, or while reset is held.
  assign memWe           = MemWriteM && rst && (aluSt != UNCORR) && (wdSt != UNCORR);

  // Number of words corrected this cycle and the saturated counter update.
  always_comb begin
    corrNum   = 2'(aluSt == CORR) + 2'(wdSt == CORR) + 2'(pcSt == CORR);
    countSum  = {1'b0, ecc_corr_count} + (CNT_W+1)'(corrNum);
    countNext = countSum[CNT_W] ? '1 : countSum[CNT_W-1:0];
  end

  // Data memory write port; contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (memWe) dmem[memIdx] <= wdData;
  end

  // MEM/WB register with read-before-write memory read; squash on uncorrectable input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
    end else begin
      RegWriteW   <= RegWriteM & ~anyUncorr;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      ALU_ResultW <= aluData;
      ReadDataW   <= dmem[memIdx];
      PCPlus4W    <= pcData;
    end
  end

  // Fault statistics; err_clr wins over same-cycle events, the pulse is unaffected by it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ecc_corr_pulse    <= 1'b0;
      ecc_uncorr_sticky <= 1'b0;
      ecc_corr_count    <= '0;
    end else begin
      ecc_corr_pulse <= (corrNum != 2'd0);
      if (err_clr) begin
        ecc_uncorr_sticky <= 1'b0;
        ecc_corr_count    <= '0;
      end else begin
        ecc_corr_count <= countNext;
        if (anyUncorr) ecc_uncorr_sticky <= 1'b1;
      end
    end
  end

`ifdef ECC_ERR_LOG_EN
  logic           logHit;
  logic [1:0]     logSrc;
  logic [SYN_W:0] logSyn;

  // Pick the lowest-numbered non-clean source this cycle.
  always_comb begin
    logHit = 1'b1;
    logSrc = 2'd0;
    logSyn = {aluPar, aluSyn};
    if (aluSt != CLEAN) begin
      logSrc = 2'd0;
      logSyn = {aluPar, aluSyn};
    end else if (wdSt != CLEAN) begin
      logSrc = 2'd1;
      logSyn = {wdPar, wdSyn};
    end else if (pcSt != CLEAN) begin
      logSrc = 2'd2;
      logSyn = {pcPar, pcSyn};
    end else begin
      logHit = 1'b0;
    end
  end

  // First-fault capture, held until err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_log_valid <= 1'b0;
      err_log_syn   <= '0;
      err_log_src   <= '0;
    end else if (err_clr) begin
      err_log_valid <= 1'b0;
      err_log_syn   <= '0;
      err_log_src   <= '0;
    end else if (!err_log_valid && logHit) begin
      err_log_valid <= 1'b1;
      err_log_syn   <= logSyn;
      err_log_src   <= logSrc;
    end
  end
`else
  logic unusedSyndromes;
  assign unusedSyndromes = ^{aluSyn, aluPar, wdSyn, wdPar, pcSyn, pcPar};
`endif

endmodule

// File: tb/tb_memory_cycle_ecc.sv
// tb/tb_memory_cycle_ecc.sv - directed self-checking bench for memory_cycle_ecc
module tb_memory_cycle_ecc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0, err_clr = 1'b0;
  logic [4:0]  RD_M = '0;
  logic [38:0] ALU_ResultM_ECC = '0, WriteDataM_ECC = '0, PCPlus4M_ECC = '0;
  logic [31:0] ALU_ResultM_Out, ALU_ResultW, ReadDataW, PCPlus4W;
  logic        RegWriteW, ResultSrcW, ecc_corr_pulse, ecc_uncorr_sticky;
  logic [4:0]  RD_W;
  logic [15:0] ecc_corr_count;

  int checkCount = 0;
  int failCount  = 0;

  memory_cycle_ecc #(.DMEM_AW(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .ALU_ResultM_ECC(ALU_ResultM_ECC), .WriteDataM_ECC(WriteDataM_ECC), .PCPlus4M_ECC(PCPlus4M_ECC),
    .err_clr(err_clr), .ALU_ResultM_Out(ALU_ResultM_Out),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .ecc_corr_pulse(ecc_corr_pulse), .ecc_uncorr_sticky(ecc_uncorr_sticky),
    .ecc_corr_count(ecc_corr_count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Hamming(38,32) plus overall parity at bit 0.
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] c;
    int j;
    logic p;
    c = '0;
    j = 0;
    for (int i = 1; i < 39; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      p = 1'b0;
      for (int i = 1; i < 39; i++) if (((i >> k) & 1) == 1) p = p ^ c[i];
      c[1 << k] = p;
    end
    c[0] = ^c[38:1];
    return c;
  endfunction

  function automatic logic [38:0] flip(input logic [38:0] c, input int b);
    return c ^ (39'd1 << b);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [38:0] a, input logic [38:0] w, input logic [38:0] p,
                       input logic mw, input logic rw, input logic rs, input logic [4:0] rd);
    ALU_ResultM_ECC = a;
    WriteDataM_ECC  = w;
    PCPlus4M_ECC    = p;
    MemWriteM       = mw;
    RegWriteM       = rw;
    ResultSrcM      = rs;
    RD_M            = rd;
  endtask

  initial begin
    drive(enc(32'h0), enc(32'h0), enc(32'h0), 1'b0, 1'b0, 1'b0, 5'd0);
    #12;
    checkVal("rst_regwrite", RegWriteW, 0);
    checkVal("rst_alu", ALU_ResultW, 0);
    checkVal("rst_pc4", PCPlus4W, 0);
    checkVal("rst_count", ecc_corr_count, 0);
    checkVal("rst_sticky", ecc_uncorr_sticky, 0);
    checkVal("rst_pulse", ecc_corr_pulse, 0);
    @(negedge clk);
    rst = 1'b1;

    // clean store then read back
    drive(enc(32'h10), enc(32'hDEADBEEF), enc(32'h14), 1'b1, 1'b0, 1'b0, 5'd3);
    #1 checkVal("fwd_clean", ALU_ResultM_Out, 32'h10);
    tick;
    checkVal("st_count", ecc_corr_count, 0);
    checkVal("st_pulse", ecc_corr_pulse, 0);
    checkVal("st_alu", ALU_ResultW, 32'h10);
    checkVal("st_pc4", PCPlus4W, 32'h14);
    drive(enc(32'h10), enc(32'h0), enc(32'h18), 1'b0, 1'b1, 1'b1, 5'd7);
    tick;
    checkVal("rd_data", ReadDataW, 32'hDEADBEEF);
    checkVal("rd_regwrite", RegWriteW, 1);
    checkVal("rd_ressrc", ResultSrcW, 1);
    checkVal("rd_rd", RD_W, 7);

    // single flip on store data is corrected before the write
    drive(enc(32'h20), flip(enc(32'h12345678), 5), enc(32'h1C), 1'b1, 1'b0, 1'b0, 5'd0);
    tick;
    checkVal("sec_pulse", ecc_corr_pulse, 1);
    checkVal("sec_count", ecc_corr_count, 1);
    drive(flip(enc(32'h20), 12), enc(32'h0), enc(32'h20), 1'b0, 1'b1, 1'b1, 5'd9);
    #1 checkVal("fwd_corr", ALU_ResultM_Out, 32'h20);
    tick;
    checkVal("sec_rdback", ReadDataW, 32'h12345678);
    checkVal("sec_count2", ecc_corr_count, 2);

    // double flip on address: no write, squash, sticky
    drive(enc(32'h30), enc(32'hCAFEF00D), enc(32'h24), 1'b1, 1'b0, 1'b0, 5'd0);
    tick;
    drive(flip(flip(enc(32'h30), 3), 9), enc(32'h11111111), enc(32'h28), 1'b1, 1'b1, 1'b0, 5'd4);
    tick;
    checkVal("ded_squash", RegWriteW, 0);
    checkVal("ded_sticky", ecc_uncorr_sticky, 1);
    checkVal("ded_alu_raw", ALU_ResultW, 32'h21);
    checkVal("ded_rd", RD_W, 4);
    checkVal("ded_pulse", ecc_corr_pulse, 0);
    drive(enc(32'h30), enc(32'h0), enc(32'h2C), 1'b0, 1'b1, 1'b1, 5'd5);
    tick;
    checkVal("ded_mem", ReadDataW, 32'hCAFEF00D);
    checkVal("ded_sticky_hold", ecc_uncorr_sticky, 1);

    // three corrections in one cycle, including the parity bit itself
    drive(flip(enc(32'h10), 38), flip(enc(32'h55), 20), flip(enc(32'h30), 0), 1'b0, 1'b1, 1'b1, 5'd6);
    #1 checkVal("fwd_b38", ALU_ResultM_Out, 32'h10);
    tick;
    checkVal("tri_count", ecc_corr_count, 5);
    checkVal("tri_pc4", PCPlus4W, 32'h30);
    checkVal("tri_rd", ReadDataW, 32'hDEADBEEF);

    // err_clr beats same-cycle events
    err_clr = 1'b1;
    drive(enc(32'h10), flip(enc(32'h66), 7), flip(flip(enc(32'h34), 1), 2), 1'b0, 1'b1, 1'b0, 5'd2);
    tick;
    err_clr = 1'b0;
    checkVal("clr_count", ecc_corr_count, 0);
    checkVal("clr_sticky", ecc_uncorr_sticky, 0);
    checkVal("clr_pulse", ecc_corr_pulse, 1);
    checkVal("clr_squash", RegWriteW, 0);

    // saturation
    drive(flip(enc(32'h10), 38), flip(enc(32'h55), 20), flip(enc(32'h30), 0), 1'b0, 1'b0, 1'b0, 5'd0);
    repeat (21844) tick;
    checkVal("sat_fffc", ecc_corr_count, 32'hFFFC);
    drive(flip(enc(32'h10), 38), flip(enc(32'h55), 20), enc(32'h30), 1'b0, 1'b0, 1'b0, 5'd0);
    tick;
    checkVal("sat_fffe", ecc_corr_count, 32'hFFFE);
    drive(flip(enc(32'h10), 38), flip(enc(32'h55), 20), flip(enc(32'h30), 0), 1'b0, 1'b0, 1'b0, 5'd0);
    tick;
    checkVal("sat_ffff", ecc_corr_count, 32'hFFFF);
    drive(enc(32'h10), enc(32'h55), flip(enc(32'h30), 17), 1'b0, 1'b0, 1'b0, 5'd0);
    tick;
    checkVal("sat_hold", ecc_corr_count, 32'hFFFF);

    // asynchronous reset aborts a pending store
    drive(enc(32'h40), enc(32'hA5A5A5A5), enc(32'h44), 1'b1, 1'b1, 1'b0, 5'd1);
    tick;
    checkVal("pre_rst_alu", ALU_ResultW, 32'h40);
    drive(enc(32'h40), enc(32'h5A5A5A5A), enc(32'h48), 1'b1, 1'b1, 1'b0, 5'd1);
    #3 rst = 1'b0;
    #1;
    checkVal("arst_alu", ALU_ResultW, 0);
    checkVal("arst_regwrite", RegWriteW, 0);
    checkVal("arst_count", ecc_corr_count, 0);
    checkVal("arst_rd", RD_W, 0);
    tick;
    checkVal("arst_hold", PCPlus4W, 0);
    #3 rst = 1'b1;
    drive(enc(32'h40), enc(32'h0), enc(32'h0), 1'b0, 1'b1, 1'b1, 5'd2);
    tick;
    checkVal("arst_nowrite", ReadDataW, 32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
